// File: rtl/nubus_pkg.sv
// Shared NuBus definitions: slave FSM state codes, byte-lane enables and the
// TM/AD[1:0] codes used by the NuBus interface block and its memory target.
package nubus_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WAIT    = 2'd1;
  localparam logic [1:0] ST_ACCESS  = 2'd2;
  localparam logic [1:0] ST_RELEASE = 2'd3;

  localparam logic [3:0] LANE_NONE = 4'b0000;
  localparam logic [3:0] LANE_0    = 4'b0001;
  localparam logic [3:0] LANE_1    = 4'b0010;
  localparam logic [3:0] LANE_2    = 4'b0100;
  localparam logic [3:0] LANE_3    = 4'b1000;
  localparam logic [3:0] LANE_LO16 = 4'b0011;
  localparam logic [3:0] LANE_HI16 = 4'b1100;
  localparam logic [3:0] LANE_ALL  = 4'b1111;

  // Acknowledge status driven on TM[1:0] during the ack cycle.
  localparam logic [1:0] TM_ACK_COMPLETE = 2'b00;
  localparam logic [1:0] TM_ACK_ERROR    = 2'b01;
  localparam logic [1:0] TM_ACK_TIMEOUT  = 2'b10;
  localparam logic [1:0] TM_ACK_RETRY    = 2'b11;

  // Transfer size carried on AD[1:0] for word/halfword accesses.
  localparam logic [1:0] AD_WORD      = 2'b00;
  localparam logic [1:0] AD_HALF_LO   = 2'b01;
  localparam logic [1:0] AD_HALF_HI   = 2'b10;
  localparam logic [1:0] AD_BYTE_MODE = 2'b11;

endpackage

// File: rtl/nubus_bram.sv
// Single-port 32-bit RAM with four byte enables and synchronous
// read-before-write; only the output register is reset.
module nubus_bram
  import nubus_pkg::*;
#(
  parameter int unsigned ADDR_W     = 8,
  parameter logic [31:0] INIT_VALUE = 32'h0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [3:0]        we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  // NOTE: the array is never reset -- a reset loop over every word would kill
  // RAM inference; power-up content comes from the declaration initialiser.
  logic [31:0] mem [2**ADDR_W] = '{default: INIT_VALUE};

  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 4; i++) begin
        if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Old word is captured at the same edge that writes the new lanes.
  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (en) rdata <= mem[addr];
  end

endmodule

// File: rtl/nubus_wait_mem.sv
// Wait-state RAM target behind the NuBus mem_* port; one access per request.
// Define NUBUS_WAIT_MEM_WAIT_EN for programmable wait clocks, else zero-wait.
module nubus_wait_mem
  import nubus_pkg::*;
#(
  parameter int unsigned MEM_DEPTH_LOG2 = 8,
  parameter logic [31:0] INIT_VALUE     = 32'h0
) (
  input  logic        mem_clk,
  input  logic        mem_reset,
  input  logic        mem_valid,
  input  logic [3:0]  mem_write,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata_o,
  input  logic        mem_myslot,
  input  logic        mem_myexp,
  input  logic [1:0]  mem_wait_clocks,
  output logic        mem_ready_o,
  output logic        mem_write_o
);

  logic [1:0]                state;
  logic [MEM_DEPTH_LOG2-1:0] addr_q;
  logic [3:0]                we_q;
  logic [31:0]               wdata_q;
  logic                      sel;
  logic                      ram_en;

  assign sel    = mem_valid & (mem_myslot | mem_myexp);
  // A reset arriving in ACCESS must not let the pending write land.
  assign ram_en = (state == ST_ACCESS) & ~mem_reset;

`ifdef NUBUS_WAIT_MEM_WAIT_EN
  logic [1:0] cnt;
  logic       unused_addr;
  assign unused_addr = ^{mem_addr[31:MEM_DEPTH_LOG2+2], mem_addr[1:0]};
`else
  logic       unused_inputs;
  assign unused_inputs = ^{mem_addr[31:MEM_DEPTH_LOG2+2], mem_addr[1:0], mem_wait_clocks};
`endif

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge mem_clk) begin
    if (mem_reset) begin
      state       <= ST_IDLE;
      mem_ready_o <= 1'b0;
      mem_write_o <= 1'b0;
`ifdef NUBUS_WAIT_MEM_WAIT_EN
      cnt         <= 2'd0;
`endif
    end else begin
      mem_ready_o <= 1'b0;
      mem_write_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (sel) begin
`ifdef NUBUS_WAIT_MEM_WAIT_EN
            cnt   <= mem_wait_clocks;
            state <= (mem_wait_clocks == 2'd0) ? ST_ACCESS : ST_WAIT;
`else
            state <= ST_ACCESS;
`endif
          end
        end
`ifdef NUBUS_WAIT_MEM_WAIT_EN
        ST_WAIT: begin
          cnt <= cnt - 2'd1;
          if (cnt == 2'd1) state <= ST_ACCESS;
        end
`endif
        ST_ACCESS: begin
          mem_ready_o <= 1'b1;
          mem_write_o <= (we_q != LANE_NONE);
          state       <= ST_RELEASE;
        end
        ST_RELEASE: begin
          // Wait for the master to drop valid so one request is one access.
          if (!mem_valid) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Request capture: datapath only, qualified by the FSM, so no reset needed.
  always_ff @(posedge mem_clk) begin
    if (state == ST_IDLE && sel) begin
      addr_q  <= mem_addr[MEM_DEPTH_LOG2+1:2];
      we_q    <= mem_write;
      wdata_q <= mem_wdata;
    end
  end

  nubus_bram #(
    .ADDR_W     (MEM_DEPTH_LOG2),
    .INIT_VALUE (INIT_VALUE)
  ) u_bram (
    .clk   (mem_clk),
    .rst   (mem_reset),
    .en    (ram_en),
    .we    (we_q),
    .addr  (addr_q),
    .wdata (wdata_q),
    .rdata (mem_rdata_o)
  );

endmodule

// File: tb/tb_nubus_wait_mem.sv
// Directed bench for nubus_wait_mem: lanes, latency, unselected/held valid,
// reset mid-access and address aliasing, with hand-computed expectations.
module tb_nubus_wait_mem;

  localparam int unsigned DL2 = 8;

  logic        mem_clk = 1'b0;
  logic        mem_reset;
  logic        mem_valid;
  logic [3:0]  mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata_o;
  logic        mem_myslot;
  logic        mem_myexp;
  logic [1:0]  mem_wait_clocks;
  logic        mem_ready_o;
  logic        mem_write_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 mem_clk = ~mem_clk;

  nubus_wait_mem #(.MEM_DEPTH_LOG2(DL2), .INIT_VALUE(32'h0)) dut (
    .mem_clk         (mem_clk),
    .mem_reset       (mem_reset),
    .mem_valid       (mem_valid),
    .mem_write       (mem_write),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_rdata_o     (mem_rdata_o),
    .mem_myslot      (mem_myslot),
    .mem_myexp       (mem_myexp),
    .mem_wait_clocks (mem_wait_clocks),
    .mem_ready_o     (mem_ready_o),
    .mem_write_o     (mem_write_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Cycle (accept edge = 1) in which ready is expected.
  function automatic int exp_lat(input logic [1:0] wt);
`ifdef NUBUS_WAIT_MEM_WAIT_EN
    return int'(wt) + 2;
`else
    return 2;
`endif
  endfunction

  // One bounded request; inputs are scrambled after accept to prove latching.
  task automatic access(input logic [3:0] we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [1:0] wt, input logic slot, input logic expn, input int hold,
                        output int rdy_at, output int n_rdy, output int n_wr,
                        output logic [31:0] rd);
    int seen_at;
    rdy_at = 0; n_rdy = 0; n_wr = 0; rd = 32'hxxxx_xxxx; seen_at = -1;
    @(negedge mem_clk);
    mem_valid = 1'b1; mem_write = we; mem_addr = addr; mem_wdata = wd;
    mem_wait_clocks = wt; mem_myslot = slot; mem_myexp = expn;
    for (int c = 1; c <= 16; c++) begin
      @(posedge mem_clk); #1;
      if (mem_ready_o === 1'b1) begin
        if (n_rdy == 0) begin rdy_at = c; rd = mem_rdata_o; seen_at = c; end
        n_rdy++;
      end
      if (mem_write_o === 1'b1) n_wr++;
      if (seen_at > 0 && c >= seen_at + hold) mem_valid = 1'b0;
      if (c == 1) begin
        mem_addr = ~addr; mem_wdata = ~wd; mem_write = ~we; mem_wait_clocks = ~wt;
      end
    end
    mem_valid = 1'b0; mem_myslot = 1'b0; mem_myexp = 1'b0;
  endtask

  // Selected request with full checks on latency, pulse width, write flag, data.
  task automatic xfer(input string tag, input logic [3:0] we, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [1:0] wt, input logic slot,
                      input logic expn, input logic [31:0] exp_rd);
    int rdy_at, n_rdy, n_wr;
    logic [31:0] rd;
    access(we, addr, wd, wt, slot, expn, 0, rdy_at, n_rdy, n_wr, rd);
    check({tag, "_lat"},   32'(rdy_at), 32'(exp_lat(wt)));
    check({tag, "_width"}, 32'(n_rdy),  32'd1);
    check({tag, "_wr"},    32'(n_wr),   (we != 4'h0) ? 32'd1 : 32'd0);
    check({tag, "_rdata"}, rd,          exp_rd);
  endtask

  initial begin
    int rdy_at, n_rdy, n_wr, cnt;
    logic [31:0] rd;

    mem_reset = 1'b1; mem_valid = 1'b0; mem_write = 4'h0; mem_addr = '0; mem_wdata = '0;
    mem_myslot = 1'b0; mem_myexp = 1'b0; mem_wait_clocks = 2'd0;
    repeat (3) @(posedge mem_clk);
    #1;
    check("rst_ready", 32'(mem_ready_o), 32'd0);
    check("rst_write", 32'(mem_write_o), 32'd0);
    check("rst_rdata", mem_rdata_o, 32'h0);
    @(negedge mem_clk); mem_reset = 1'b0;

    // Full word write/read; write returns the pre-write word.
    xfer("w0", 4'hF, 32'hF000_0000, 32'h8765_4321, 2'd1, 1'b1, 1'b0, 32'h0000_0000);
    xfer("r0", 4'h0, 32'hF000_0000, 32'h0,         2'd1, 1'b1, 1'b0, 32'h8765_4321);

    // Byte lanes on fresh words.
    xfer("w_lo16", 4'h3, 32'hF000_0004, 32'h8765_4321, 2'd0, 1'b1, 1'b0, 32'h0);
    xfer("r_lo16", 4'h0, 32'hF000_0004, 32'h0,         2'd0, 1'b1, 1'b0, 32'h0000_4321);
    xfer("w_hi16", 4'hC, 32'hF000_0008, 32'h8765_4321, 2'd2, 1'b0, 1'b1, 32'h0);
    xfer("r_hi16", 4'h0, 32'hF000_0008, 32'h0,         2'd2, 1'b0, 1'b1, 32'h8765_0000);
    xfer("w_b0",   4'h1, 32'hF000_000C, 32'h8765_4321, 2'd3, 1'b1, 1'b0, 32'h0);
    xfer("r_b0",   4'h0, 32'hF000_000C, 32'h0,         2'd3, 1'b1, 1'b0, 32'h0000_0021);
    xfer("w_b3",   4'h8, 32'hF000_0018, 32'h8765_4321, 2'd1, 1'b1, 1'b1, 32'h0);
    xfer("r_b3",   4'h0, 32'hF000_0018, 32'h0,         2'd1, 1'b1, 1'b1, 32'h8700_0000);

    // Wait sweep on reads of word 0.
    xfer("wait0", 4'h0, 32'hF000_0000, 32'h0, 2'd0, 1'b1, 1'b0, 32'h8765_4321);
    xfer("wait1", 4'h0, 32'hF000_0000, 32'h0, 2'd1, 1'b1, 1'b0, 32'h8765_4321);
    xfer("wait2", 4'h0, 32'hF000_0000, 32'h0, 2'd2, 1'b0, 1'b1, 32'h8765_4321);
    xfer("wait3", 4'h0, 32'hF000_0000, 32'h0, 2'd3, 1'b1, 1'b0, 32'h8765_4321);

    // Unselected write with valid held: no ready, RAM untouched.
    access(4'hF, 32'hF000_0000, 32'hDEAD_BEEF, 2'd0, 1'b0, 1'b0, 0, rdy_at, n_rdy, n_wr, rd);
    check("unsel_ready", 32'(n_rdy), 32'd0);
    check("unsel_wr",    32'(n_wr),  32'd0);
    xfer("unsel_rb", 4'h0, 32'hF000_0000, 32'h0, 2'd0, 1'b1, 1'b0, 32'h8765_4321);

    // Valid held three cycles past ready: still a single access.
    access(4'h0, 32'hF000_0004, 32'h0, 2'd1, 1'b1, 1'b0, 3, rdy_at, n_rdy, n_wr, rd);
    check("hold_ready", 32'(n_rdy), 32'd1);
    check("hold_rdata", rd, 32'h0000_4321);

    // Reset while the write to word 8 is pending.
    @(negedge mem_clk);
    mem_valid = 1'b1; mem_write = 4'hF; mem_addr = 32'hF000_0020; mem_wdata = 32'h1234_5678;
    mem_wait_clocks = 2'd3; mem_myslot = 1'b1;
    @(posedge mem_clk); #1;
    @(negedge mem_clk); mem_reset = 1'b1;
    @(posedge mem_clk); #1;
    cnt = (mem_ready_o === 1'b1) ? 1 : 0;
    @(negedge mem_clk); mem_reset = 1'b0; mem_valid = 1'b0; mem_myslot = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge mem_clk); #1;
      if (mem_ready_o === 1'b1) cnt++;
    end
    check("rstmid_ready", 32'(cnt), 32'd0);
    check("rstmid_rdata", mem_rdata_o, 32'h0);
    xfer("rstmid_rb", 4'h0, 32'hF000_0020, 32'h0, 2'd0, 1'b1, 1'b0, 32'h0);

    // Aliasing: byte offset 4<<DL2 maps back to word 0.
    xfer("alias_w", 4'hF, 32'h0000_0000, 32'hAAAA_AAAA, 2'd0, 1'b1, 1'b0, 32'h8765_4321);
    xfer("alias_r", 4'h0, 32'(4) << DL2, 32'h0,         2'd2, 1'b1, 1'b0, 32'hAAAA_AAAA);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/nubus_wait_mem.md
Name: nubus_wait_mem

Overview:
- Byte-lane-writable, word-organised RAM model used as the slave-side target of the NuBus interface.
- Accepts one access per mem_valid request, inserts a programmable number of wait clocks, then pulses mem_ready_o.
- Sits behind the NuBus interface's mem_* port. Its clock is the inverted NuBus clock.

Parameters:
- MEM_DEPTH_LOG2, 8, log2 of the word count (default 256 x 32-bit words).
- INIT_VALUE, 32'h0, power-up content of every word.

Ports:
- mem_clk  in  1  clock; all logic updates on the rising edge.
- mem_reset  in  1  synchronous, active-high reset.
- mem_valid  in  1  access request; held high by the master until it sees mem_ready_o.
- mem_write  in  4  active-high byte enables; bit i writes bits 8i+7:8i. All zero means read.
- mem_addr  in  32  byte address; only bits MEM_DEPTH_LOG2+1:2 are used.
- mem_wdata  in  32  write data.
- mem_rdata_o  out  32  read data.
- mem_myslot  in  1  access targets this card's slot space.
- mem_myexp  in  1  access targets this card's expansion space.
- mem_wait_clocks  in  2  number of wait clocks, 0..3.
- mem_ready_o  out  1  one-cycle completion pulse.
- mem_write_o  out  1  debug: high in any cycle where a byte was written.

Behaviour:
- Reset: state IDLE, mem_ready_o=0, mem_write_o=0, mem_rdata_o=0, wait counter=0. RAM contents are not affected by reset.
- RAM content is INIT_VALUE at configuration.
- sel = mem_valid & (mem_myslot | mem_myexp).
- Unselected requests are ignored: ready is never asserted and the RAM is untouched. Bus timeout is the master's responsibility.
- Word index = mem_addr[MEM_DEPTH_LOG2+1:2]. Upper bits are ignored, so addresses alias modulo the depth. mem_addr[1:0] is ignored.
- State IDLE:
  - If sel is sampled, latch addr, write enables and wdata, and load cnt = mem_wait_clocks.
  - If cnt = 0, go to ACCESS; otherwise go to WAIT.
- State WAIT: decrement cnt each clock; go to ACCESS when cnt reaches 1.
- State ACCESS (one cycle, registered at the edge entering the next state):
  - Write each enabled byte lane.
  - Load mem_rdata_o with the full pre-write word.
  - Set mem_ready_o=1 for exactly one cycle.
  - Set mem_write_o = |write enables for the same cycle.
  - Go to RELEASE.
- Read data is never masked by this block; lane selection/masking belongs to the master.
- Latency: mem_ready_o is high in cycle mem_wait_clocks+2, counting the accept edge as edge 1. With wait=1 it is high in the 3rd cycle after acceptance.
- State RELEASE:
  - mem_ready_o=0.
  - Stay until mem_valid is sampled low, then go to IDLE.
  - This prevents a still-high valid from triggering a second access.
- mem_rdata_o holds its value until the next ACCESS.
- mem_wait_clocks is sampled only at accept; changes mid-access are ignored.
- Reset mid-access: return to IDLE immediately. A pending write is discarded and no ready pulse is issued.
- Inputs latched at accept are used for the access. Changes to mem_addr/mem_wdata during WAIT do not matter.

Optional Feature:
- Macro: NUBUS_WAIT_MEM_WAIT_EN.
- Defined: wait states follow mem_wait_clocks as above.
- Undefined: mem_wait_clocks is ignored and cnt is always 0 (zero-wait; ready in the 2nd cycle after accept). The WAIT state and counter are not built.

Decomposition:
- Package nubus_pkg: state enum (IDLE, WAIT, ACCESS, RELEASE) and byte-lane constants.
- The package also holds the NuBus TM/AD[1:0] codes shared with the interface block.
- One natural sub-module, nubus_bram: 32-bit RAM with 4 byte enables, one port, synchronous read-before-write.

Test Plan:
- Word write then read: write 32'h87654321, we=4'hF, addr F0000000, myslot=1, wait=1. Read back 87654321; ready asserted 3 cycles after accept; mem_write_o pulses once.
- Half/byte lanes: write 87654321 with we=4'h3 at F0000004, then read. Expect 00004321.
  - we=4'hC at F0000008: expect 87650000.
  - we=4'h1 at +12: expect 00000021.
  - we=4'h8 at +24: expect 87000000.
- Wait sweep: wait=0,1,2,3. Expect ready exactly in cycles 2,3,4,5 after accept, each one cycle wide.
- Unselected / held valid:
  - myslot=myexp=0 with valid high for 10 cycles: no ready, RAM unchanged.
  - Valid held 3 cycles past ready: only one access and one ready.
- Reset mid-wait: wait=3 write, assert mem_reset in the WAIT state. Expect no ready and the word unchanged (still 0).
- Aliasing: write AAAAAAAA at word 0, read at byte offset 4<<MEM_DEPTH_LOG2. Expect AAAAAAAA.
